// File: rtl/instr_encoder_pkg.sv
// Shared encoder definitions: opclass codes, ALU_* codes, RV32I opcodes and funct3/funct7 fields.
// Optional immediate range checking is enabled with ENCODER_RANGE_CHECK_EN.
package instr_encoder_pkg;

  typedef enum logic [3:0] {
    OcOp     = 4'd0,
    OcOpImm  = 4'd1,
    OcLui    = 4'd2,
    OcAuipc  = 4'd3,
    OcJal    = 4'd4,
    OcJalr   = 4'd5,
    OcBranch = 4'd6,
    OcStore  = 4'd7,
    OcLoad   = 4'd8,
    OcHalt   = 4'd9
  } opclass_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } enc_state_e;

  // ALU_* codes as the decoder emits them
  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SUB  = 6'd1;
  localparam logic [5:0] ALU_SLL  = 6'd2;
  localparam logic [5:0] ALU_SLT  = 6'd3;
  localparam logic [5:0] ALU_SLTU = 6'd4;
  localparam logic [5:0] ALU_XOR  = 6'd5;
  localparam logic [5:0] ALU_SRL  = 6'd6;
  localparam logic [5:0] ALU_SRA  = 6'd7;
  localparam logic [5:0] ALU_OR   = 6'd8;
  localparam logic [5:0] ALU_AND  = 6'd9;
  localparam logic [5:0] ALU_BEQ  = 6'd10;
  localparam logic [5:0] ALU_BNE  = 6'd11;
  localparam logic [5:0] ALU_BLT  = 6'd12;
  localparam logic [5:0] ALU_BGE  = 6'd13;
  localparam logic [5:0] ALU_BLTU = 6'd14;
  localparam logic [5:0] ALU_BGEU = 6'd15;
  localparam logic [5:0] ALU_LB   = 6'd16;
  localparam logic [5:0] ALU_LH   = 6'd17;
  localparam logic [5:0] ALU_LW   = 6'd18;
  localparam logic [5:0] ALU_LBU  = 6'd19;
  localparam logic [5:0] ALU_LHU  = 6'd20;
  localparam logic [5:0] ALU_SB   = 6'd21;
  localparam logic [5:0] ALU_SH   = 6'd22;
  localparam logic [5:0] ALU_SW   = 6'd23;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  localparam logic [31:0] HALT_WORD = 32'h0000_0073;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_B    = 3'd0;
  localparam logic [2:0] F3_H    = 3'd1;
  localparam logic [2:0] F3_W    = 3'd2;
  localparam logic [2:0] F3_BU   = 3'd4;
  localparam logic [2:0] F3_HU   = 3'd5;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // True when imm is representable as a signed value of the given width
  function automatic logic fits_signed(input logic [31:0] imm, input int unsigned bits);
    logic [31:0] hi;
    hi = $signed(imm) >>> (bits - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: micro-op fields in, machine word and reject flag out.
// With ENCODER_RANGE_CHECK_EN defined, immediates that do not fit their field are rejected.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  opclass,
  input  logic [5:0]  alucode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        reject
);

  logic [2:0] alu_f3, br_f3, ld_f3, st_f3;
  logic       alu_ok, alu_alt, alu_shift, br_ok, ld_ok, st_ok;
  logic [6:0] alu_f7;
  logic       legal;

  always_comb begin
    alu_f3    = F3_ADD;
    alu_ok    = 1'b1;
    alu_alt   = 1'b0;
    alu_shift = 1'b0;
    case (alucode)
      ALU_ADD:  alu_f3 = F3_ADD;
      ALU_SUB:  begin alu_f3 = F3_ADD; alu_alt = 1'b1; end
      ALU_SLL:  begin alu_f3 = F3_SLL; alu_shift = 1'b1; end
      ALU_SLT:  alu_f3 = F3_SLT;
      ALU_SLTU: alu_f3 = F3_SLTU;
      ALU_XOR:  alu_f3 = F3_XOR;
      ALU_SRL:  begin alu_f3 = F3_SR; alu_shift = 1'b1; end
      ALU_SRA:  begin alu_f3 = F3_SR; alu_shift = 1'b1; alu_alt = 1'b1; end
      ALU_OR:   alu_f3 = F3_OR;
      ALU_AND:  alu_f3 = F3_AND;
      default:  alu_ok = 1'b0;
    endcase
  end

  assign alu_f7 = alu_alt ? F7_ALT : F7_ZERO;

  always_comb begin
    br_f3 = F3_BEQ;
    br_ok = 1'b1;
    case (alucode)
      ALU_BEQ:  br_f3 = F3_BEQ;
      ALU_BNE:  br_f3 = F3_BNE;
      ALU_BLT:  br_f3 = F3_BLT;
      ALU_BGE:  br_f3 = F3_BGE;
      ALU_BLTU: br_f3 = F3_BLTU;
      ALU_BGEU: br_f3 = F3_BGEU;
      default:  br_ok = 1'b0;
    endcase
  end

  always_comb begin
    ld_f3 = F3_W;
    ld_ok = 1'b1;
    case (alucode)
      ALU_LB:  ld_f3 = F3_B;
      ALU_LH:  ld_f3 = F3_H;
      ALU_LW:  ld_f3 = F3_W;
      ALU_LBU: ld_f3 = F3_BU;
      ALU_LHU: ld_f3 = F3_HU;
      default: ld_ok = 1'b0;
    endcase
  end

  always_comb begin
    st_f3 = F3_W;
    st_ok = 1'b1;
    case (alucode)
      ALU_SB:  st_f3 = F3_B;
      ALU_SH:  st_f3 = F3_H;
      ALU_SW:  st_f3 = F3_W;
      default: st_ok = 1'b0;
    endcase
  end

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (opclass_e'(opclass))
      OcOp: begin
        legal = alu_ok;
        word  = {alu_f7, rs2, rs1, alu_f3, rd, OPC_OP};
      end
      OcOpImm: begin
        // SUB has no immediate form
        legal = alu_ok && !(alu_alt && !alu_shift);
        if (alu_shift) word = {alu_f7, imm[4:0], rs1, alu_f3, rd, OPC_OPIMM};
        else           word = {imm[11:0], rs1, alu_f3, rd, OPC_OPIMM};
      end
      OcLui: begin
        legal = (alucode == ALU_ADD);
        word  = {imm[31:12], rd, OPC_LUI};
      end
      OcAuipc: begin
        legal = (alucode == ALU_ADD);
        word  = {imm[31:12], rd, OPC_AUIPC};
      end
      OcJal: begin
        legal = (alucode == ALU_ADD);
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      end
      OcJalr: begin
        legal = (alucode == ALU_ADD);
        word  = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
      end
      OcBranch: begin
        legal = br_ok;
        word  = {imm[12], imm[10:5], rs2, rs1, br_f3, imm[4:1], imm[11], OPC_BRANCH};
      end
      OcStore: begin
        legal = st_ok;
        word  = {imm[11:5], rs2, rs1, st_f3, imm[4:0], OPC_STORE};
      end
      OcLoad: begin
        legal = ld_ok;
        word  = {imm[11:0], rs1, ld_f3, rd, OPC_LOAD};
      end
      OcHalt: begin
        legal = (alucode == ALU_ADD);
        word  = HALT_WORD;
      end
      default: begin
        legal = 1'b0;
        word  = '0;
      end
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  logic range_bad;

  always_comb begin
    range_bad = 1'b0;
    case (opclass_e'(opclass))
      OcOpImm:               range_bad = alu_shift ? (imm[31:5] != '0) : !fits_signed(imm, 12);
      OcJalr, OcLoad, OcStore: range_bad = !fits_signed(imm, 12);
      OcBranch:              range_bad = imm[0] || !fits_signed(imm, 13);
      OcJal:                 range_bad = imm[0] || !fits_signed(imm, 21);
      OcLui, OcAuipc:        range_bad = (imm[11:0] != '0);
      default:               range_bad = 1'b0;
    endcase
  end

  assign reject = !legal || range_bad;
`else
  assign reject = !legal;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Micro-op to RV32I word encoder: run FSM, address counter and registered output stage.
// Immediate range checking is enabled with ENCODER_RANGE_CHECK_EN (see instr_pack).
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_opclass,
  input  logic [5:0]  in_alucode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [31:0] out_addr,
  output logic        err,
  output logic        busy
);

  enc_state_e  state_q;
  logic [31:0] addr_q;
  logic        out_halt_q;
  logic [31:0] pack_word;
  logic        pack_reject;
  logic        in_fire, out_fire;

  assign in_ready = (state_q == StRun) && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign busy     = (state_q == StRun);
  assign out_addr = addr_q;

  instr_pack u_pack (
    .opclass (in_opclass),
    .alucode (in_alucode),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .imm     (in_imm),
    .word    (pack_word),
    .reject  (pack_reject)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      out_valid  <= 1'b0;
      out_word   <= '0;
      out_halt_q <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StRun;
            addr_q  <= base_addr;
            err     <= 1'b0;
          end
        end
        StRun: begin
          if (out_fire) begin
            addr_q    <= addr_q + 32'd4;
            out_valid <= 1'b0;
            if (out_halt_q) begin
              state_q    <= StDone;
              out_halt_q <= 1'b0;
            end
          end
          // An op accepted in the same cycle the HALT word leaves is dropped with the run
          if (in_fire && !out_halt_q) begin
            if (pack_reject) begin
              err <= 1'b1;
            end else begin
              out_valid  <= 1'b1;
              out_word   <= pack_word;
              out_halt_q <= (opclass_e'(in_opclass) == OcHalt);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder; expectations are hand-encoded RV32I words.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, out_valid, out_ready, err, busy;
  logic [31:0] base_addr, in_imm, out_word, out_addr;
  logic [3:0]  in_opclass;
  logic [5:0]  in_alucode;
  logic [4:0]  in_rd, in_rs1, in_rs2;

  int          errors = 0;
  int          checks = 0;
  int          hs_count = 0;
  logic [31:0] exp_addr;

  instr_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opclass (in_opclass),
    .in_alucode (in_alucode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .out_addr   (out_addr),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && out_valid && out_ready) hs_count++;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  task automatic drive_op(input logic [3:0] oc, input logic [5:0] alu, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                          output bit accepted);
    in_opclass = oc; in_alucode = alu; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
    end
    if (accepted) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] base);
    base_addr = base;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; out_ready = 1'b1;
    in_opclass = '0; in_alucode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_word !== 32'h0) begin errors++; $display("FAIL rst_out_word: got %h want 0", out_word); end
    checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL rst_out_addr: got %h want 0", out_addr); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
  endtask

  task automatic test_addi_sub;
    bit acc;
    pulse_start(32'h100);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy: got %b want 1", busy); end
    drive_op(OcOpImm, ALU_ADD, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, acc);
    checks++; if (!acc || out_valid !== 1'b1 || out_word !== 32'hFFF1_0093) begin errors++; $display("FAIL addi_word: got %h valid %b want fff10093", out_word, out_valid); end
    checks++; if (out_addr !== 32'h100) begin errors++; $display("FAIL addi_addr: got %h want 100", out_addr); end
    drive_op(OcOp, ALU_SUB, 5'd3, 5'd1, 5'd2, 32'h0, acc);
    checks++; if (!acc || out_word !== 32'h4020_81B3) begin errors++; $display("FAIL sub_word: got %h want 402081b3", out_word); end
    checks++; if (out_addr !== 32'h104) begin errors++; $display("FAIL sub_addr: got %h want 104", out_addr); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || out_addr !== 32'h108) begin errors++; $display("FAIL drain_addr: got %h valid %b want 108", out_addr, out_valid); end
    exp_addr = 32'h108;
  endtask

  task automatic test_backpressure;
    bit acc;
    int h0;
    h0 = hs_count;
    out_ready = 1'b0;
    drive_op(OcOp, ALU_ADD, 5'd5, 5'd6, 5'd7, 32'h0, acc);
    checks++; if (!acc || out_word !== 32'h0073_02B3 || out_addr !== exp_addr) begin errors++; $display("FAIL bp_first: got %h @%h want 007302b3 @%h", out_word, out_addr, exp_addr); end
    in_opclass = OcOpImm; in_alucode = ALU_XOR; in_rd = 5'd8; in_rs1 = 5'd9; in_imm = 32'h7FF;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_word !== 32'h0073_02B3 || out_addr !== exp_addr) begin errors++; $display("FAIL bp_hold%0d: got %h @%h want 007302b3 @%h", c, out_word, out_addr, exp_addr); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d: got %b want 0", c, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_word !== 32'h7FF4_C413 || out_addr !== exp_addr + 32'd4) begin errors++; $display("FAIL bp_next: got %h @%h want 7ff4c413 @%h", out_word, out_addr, exp_addr + 32'd4); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || hs_count - h0 !== 2) begin errors++; $display("FAIL bp_count: got %0d valid %b want 2", hs_count - h0, out_valid); end
    exp_addr = exp_addr + 32'd8;
  endtask

  task automatic test_formats;
    logic [3:0]  ocs  [7] = '{OcStore, OcJal, OcOpImm, OcLoad, OcLui, OcAuipc, OcBranch};
    logic [5:0]  alus [7] = '{ALU_SW, ALU_ADD, ALU_SRA, ALU_LW, ALU_ADD, ALU_ADD, ALU_BLT};
    logic [4:0]  rds  [7] = '{5'd0, 5'd1, 5'd3, 5'd7, 5'd10, 5'd2, 5'd0};
    logic [4:0]  r1s  [7] = '{5'd6, 5'd0, 5'd4, 5'd2, 5'd0, 5'd0, 5'd1};
    logic [4:0]  r2s  [7] = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd2};
    logic [31:0] imms [7] = '{32'hFFFF_FFFC, 32'h8, 32'h5, 32'h10, 32'h1234_5000, 32'h1000,
                              32'hFFFF_FFF8};
    logic [31:0] exps [7] = '{32'hFE53_2E23, 32'h0080_00EF, 32'h4052_5193, 32'h0101_2383,
                              32'h1234_5537, 32'h0000_1117, 32'hFE20_CCE3};
    bit acc;
    for (int i = 0; i < 7; i++) begin
      drive_op(ocs[i], alus[i], rds[i], r1s[i], r2s[i], imms[i], acc);
      checks++; if (!acc || out_valid !== 1'b1 || out_word !== exps[i] || out_addr !== exp_addr) begin errors++; $display("FAIL fmt%0d: got %h @%h want %h @%h", i, out_word, out_addr, exps[i], exp_addr); end
      exp_addr = exp_addr + 32'd4;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal;
    bit acc;
    drive_op(OcOpImm, ALU_SUB, 5'd1, 5'd1, 5'd0, 32'h1, acc);
    checks++; if (!acc || out_valid !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL illegal_subi: got valid %b err %b want 0 1", out_valid, err); end
    checks++; if (out_addr !== exp_addr) begin errors++; $display("FAIL illegal_addr: got %h want %h", out_addr, exp_addr); end
    drive_op(4'd12, ALU_ADD, 5'd1, 5'd1, 5'd0, 32'h0, acc);
    checks++; if (!acc || out_valid !== 1'b0) begin errors++; $display("FAIL illegal_opclass: got valid %b want 0", out_valid); end
  endtask

  task automatic test_halt_restart;
    bit acc;
    drive_op(OcHalt, ALU_ADD, 5'd0, 5'd0, 5'd0, 32'h0, acc);
    checks++; if (!acc || out_valid !== 1'b1 || out_word !== 32'h0000_0073 || out_addr !== exp_addr) begin errors++; $display("FAIL halt_word: got %h @%h want 00000073 @%h", out_word, out_addr, exp_addr); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL halt_done: got busy %b ready %b valid %b want 0 0 0", busy, in_ready, out_valid); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
    pulse_start(32'h200);
    checks++; if (err !== 1'b0 || busy !== 1'b1 || out_addr !== 32'h200) begin errors++; $display("FAIL restart: got err %b busy %b addr %h want 0 1 200", err, busy, out_addr); end
    drive_op(OcOpImm, ALU_ADD, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, acc);
    checks++; if (!acc || out_word !== 32'hFFF1_0093 || out_addr !== 32'h200) begin errors++; $display("FAIL restart_word: got %h @%h want fff10093 @200", out_word, out_addr); end
    @(posedge clk); #1;
    exp_addr = 32'h204;
  endtask

  task automatic test_branch_imm;
    bit acc;
    drive_op(OcBranch, ALU_BEQ, 5'd0, 5'd1, 5'd2, 32'h3, acc);
`ifdef ENCODER_RANGE_CHECK_EN
    checks++; if (!acc || out_valid !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL beq_reject: got valid %b err %b want 0 1", out_valid, err); end
    checks++; if (out_addr !== exp_addr) begin errors++; $display("FAIL beq_addr: got %h want %h", out_addr, exp_addr); end
`else
    checks++; if (!acc || out_valid !== 1'b1 || out_word !== 32'h0020_8163 || err !== 1'b0) begin errors++; $display("FAIL beq_trunc: got %h err %b want 00208163 0", out_word, err); end
    checks++; if (out_addr !== exp_addr) begin errors++; $display("FAIL beq_addr: got %h want %h", out_addr, exp_addr); end
    exp_addr = exp_addr + 32'd4;
`endif
    drive_op(OcLui, ALU_ADD, 5'd10, 5'd0, 5'd0, 32'h1234_5000, acc);
    checks++; if (!acc || out_word !== 32'h1234_5537 || out_addr !== exp_addr) begin errors++; $display("FAIL after_beq: got %h @%h want 12345537 @%h", out_word, out_addr, exp_addr); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_inflight;
    bit acc;
    int h0;
    out_ready = 1'b0;
    drive_op(OcOp, ALU_AND, 5'd4, 5'd5, 5'd6, 32'h0, acc);
    checks++; if (!acc || out_valid !== 1'b1) begin errors++; $display("FAIL inflight_pre: got valid %b want 1", out_valid); end
    h0 = hs_count;
    out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_addr !== 32'h0 || out_word !== 32'h0) begin errors++; $display("FAIL inflight_rst: got valid %b busy %b addr %h word %h want all 0", out_valid, busy, out_addr, out_word); end
    @(posedge clk); #1;
    checks++; if (hs_count !== h0) begin errors++; $display("FAIL inflight_hs: got %0d want %0d", hs_count, h0); end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi_sub();
    test_backpressure();
    test_formats();
    test_illegal();
    test_halt_restart();
    test_branch_imm();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
